uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//   Receive-side byte FIFO of the AHB UART; consumes the uart_rx write port (we/data),
//   returns full to it so no new frame starts while storage is exhausted.
//   Buffers received bytes for the AHB register interface (read port), reports occupancy,
//   a fill-level threshold for the RX interrupt, and a sticky overflow flag.
//   Single clock domain; synchronous storage, registered read data.
// PARAMETERS
//   DEPTH   16  entries; power of two, >= 2
//   AW      4   pointer width = log2(DEPTH)
//   THRESH  8   thresh_o asserts when count_o >= THRESH; 1..DEPTH
// PORTS
//   clk        in   1     system clock, all logic on rising edge
//   rst_n      in   1     asynchronous active-low reset
//   we_i       in   1     write strobe from uart_rx, one cycle per byte
//   data_i     in   8     write byte, sampled when we_i=1
//   full_o     out  1     count_o == DEPTH
//   re_i       in   1     read strobe from bus side, one cycle per byte
//   data_o     out  8     read byte, registered, valid the cycle after an accepted read
//   empty_o    out  1     count_o == 0
//   count_o    out  AW+1  occupancy 0..DEPTH
//   thresh_o   out  1     count_o >= THRESH
//   ovf_o      out  1     sticky: write dropped because FIFO was full
//   ovf_clr_i  in   1     clears ovf_o
//   flush_i    in   1     synchronous empty of the FIFO
// BEHAVIOUR
//   Reset: rd_ptr=wr_ptr=0, count_o=0, data_o=8'h00, ovf_o=0; so empty_o=1, full_o=0,
//     thresh_o=0. Storage contents are not reset.
//   Pointers are AW bits and wrap DEPTH-1 -> 0 naturally. Occupancy is an explicit
//     AW+1-bit counter; full/empty/thresh are compares on it (no extra register).
//   Accept rules, per cycle (all evaluated on pre-edge state):
//     wr_ok = we_i & (~full_o | rd_ok); rd_ok = re_i & ~empty_o.
//     wr_ok: mem[wr_ptr]<=data_i, wr_ptr+1.  rd_ok: data_o<=mem[rd_ptr], rd_ptr+1.
//     count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
//   Full + we_i + re_i: the read frees a slot, the write is accepted, count stays DEPTH,
//     ovf_o not set.
//   Full + we_i, no read: byte dropped, state unchanged, ovf_o<=1.
//   Empty + re_i: ignored, data_o holds previous value, no error flag.
//   Empty + we_i + re_i: write accepted, read ignored (no bypass); data appears only
//     after a later read.
//   data_o latency 1 cycle from accepted re_i; holds until the next accepted read.
//   ovf_o: set has priority over ovf_clr_i in the same cycle; otherwise ovf_clr_i clears.
//   flush_i: highest priority; next cycle rd_ptr=wr_ptr=0, count_o=0, data_o=8'h00;
//     we_i/re_i in the flush cycle ignored; ovf_o unaffected (own clear).
//   Async reset mid-operation: all state returns to reset values immediately; any
//     byte in flight is lost.
// TESTING
//   Reset -> empty_o=1, full_o=0, count_o=0, data_o=00, ovf_o=0, thresh_o=0.
//   Write 8'hA5, 8'h3C; re_i x2 -> data_o=A5 one cycle after 1st read, 3C after 2nd;
//     count 2->1->0, empty_o=1.
//   Write 16 bytes 00..0F -> full_o=1, thresh_o=1 from 8th write; 17th write 8'hFF ->
//     dropped, ovf_o=1; read all 16 -> 00..0F in order; ovf_clr_i -> ovf_o=0.
//   Full FIFO, we_i=1 (8'h77) and re_i=1 same cycle -> count stays 16, ovf_o=0;
//     drain -> 8'h77 emerges last (pointer wrap exercised).
//   Empty, we_i(8'h11)+re_i same cycle -> count=1, data_o unchanged; next re_i -> 11.
//   count=5, flush_i=1 with we_i=1 -> count=0, empty_o=1, data_o=00; then DEPTH*3
//     random write/read mix against a scoreboard model -> zero mismatches.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between uart_rx and the bus: registered read data one cycle after an accepted read.
// full_o backpressures the receiver; a write while full with no read is dropped and sets sticky ovf_o.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int THRESH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [7:0]    data_i,
  output logic          full_o,
  input  logic          re_i,
  output logic [7:0]    data_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          thresh_o,
  output logic          ovf_o,
  input  logic          ovf_clr_i,
  input  logic          flush_i
);

  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] THRESH_C = (AW+1)'(THRESH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_ok;
  logic          rd_ok;
  logic          drop;

  assign full_o   = (count_o == DEPTH_C);
  assign empty_o  = (count_o == '0);
  assign thresh_o = (count_o >= THRESH_C);

  // A read in the same cycle frees the slot a write into a full FIFO needs.
  assign rd_ok = re_i & ~empty_o & ~flush_i;
  assign wr_ok = we_i & (~full_o | (re_i & ~empty_o)) & ~flush_i;
  assign drop  = we_i & full_o & ~re_i & ~flush_i;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
      data_o  <= 8'h00;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
      data_o  <= 8'h00;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_o <= mem[rd_ptr];
      end
      if (wr_ok && !rd_ok) begin
        count_o <= count_o + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count_o <= count_o - 1'b1;
      end
    end
  end

  // Flush leaves the overflow flag alone; only ovf_clr_i clears it, and a new drop wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_o <= 1'b0;
    end else if (drop) begin
      ovf_o <= 1'b1;
    end else if (ovf_clr_i) begin
      ovf_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed checks of uart_rx_fifo plus a queue-model scoreboard over a random write/read mix.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       we_i;
  logic [7:0] data_i;
  logic       full_o;
  logic       re_i;
  logic [7:0] data_o;
  logic       empty_o;
  logic [4:0] count_o;
  logic       thresh_o;
  logic       ovf_o;
  logic       ovf_clr_i;
  logic       flush_i;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo #(.DEPTH(16), .AW(4), .THRESH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (we_i),
    .data_i    (data_i),
    .full_o    (full_o),
    .re_i      (re_i),
    .data_o    (data_o),
    .empty_o   (empty_o),
    .count_o   (count_o),
    .thresh_o  (thresh_o),
    .ovf_o     (ovf_o),
    .ovf_clr_i (ovf_clr_i),
    .flush_i   (flush_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called at posedge+1; applies inputs for one edge and returns at the next posedge+1.
  task automatic cycle(input logic we, input logic [7:0] d, input logic re,
                       input logic fl, input logic clr);
    we_i = we; data_i = d; re_i = re; flush_i = fl; ovf_clr_i = clr;
    @(posedge clk);
    #1;
    we_i = 1'b0; re_i = 1'b0; flush_i = 1'b0; ovf_clr_i = 1'b0; data_i = 8'h00;
  endtask

  task automatic wr(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd();
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_ovf;

  initial begin
    rst_n = 1'b0; we_i = 1'b0; re_i = 1'b0; data_i = 8'h00;
    flush_i = 1'b0; ovf_clr_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_data", 32'(data_o), 32'h00);
    check("rst_ovf", 32'(ovf_o), 32'd0);
    check("rst_thresh", 32'(thresh_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two bytes in, two out
    wr(8'hA5);
    wr(8'h3C);
    check("two_count", 32'(count_o), 32'd2);
    rd();
    check("rd1_data", 32'(data_o), 32'hA5);
    check("rd1_count", 32'(count_o), 32'd1);
    rd();
    check("rd2_data", 32'(data_o), 32'h3C);
    check("rd2_count", 32'(count_o), 32'd0);
    check("rd2_empty", 32'(empty_o), 32'd1);

    // Fill, overflow, drain, clear
    for (int i = 0; i < 16; i++) begin
      wr(8'(i));
      check("fill_thresh", 32'(thresh_o), (i + 1 >= 8) ? 32'd1 : 32'd0);
      check("fill_full", 32'(full_o), (i == 15) ? 32'd1 : 32'd0);
    end
    wr(8'hFF);
    check("ovf_set", 32'(ovf_o), 32'd1);
    check("ovf_count", 32'(count_o), 32'd16);
    for (int i = 0; i < 16; i++) begin
      rd();
      check("drain_data", 32'(data_o), 32'(i));
    end
    check("drain_empty", 32'(empty_o), 32'd1);
    check("ovf_sticky", 32'(ovf_o), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("ovf_clr", 32'(ovf_o), 32'd0);

    // Full with simultaneous write and read; pointers wrap
    for (int i = 0; i < 16; i++) wr(8'(8'h80 + i));
    cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    check("fullrw_count", 32'(count_o), 32'd16);
    check("fullrw_ovf", 32'(ovf_o), 32'd0);
    check("fullrw_data", 32'(data_o), 32'h80);
    for (int i = 1; i < 16; i++) begin
      rd();
      check("wrap_data", 32'(data_o), 32'(8'h80 + i));
    end
    rd();
    check("wrap_last", 32'(data_o), 32'h77);
    check("wrap_empty", 32'(empty_o), 32'd1);

    // Empty with simultaneous write and read: no bypass
    cycle(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    check("emptyrw_count", 32'(count_o), 32'd1);
    check("emptyrw_data", 32'(data_o), 32'h77);
    rd();
    check("emptyrw_rd", 32'(data_o), 32'h11);
    rd();
    check("empty_rd_hold", 32'(data_o), 32'h11);
    check("empty_rd_ovf", 32'(ovf_o), 32'd0);

    // Flush overrides a concurrent write
    for (int i = 0; i < 5; i++) wr(8'(8'h40 + i));
    check("pre_flush_count", 32'(count_o), 32'd5);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    check("flush_count", 32'(count_o), 32'd0);
    check("flush_empty", 32'(empty_o), 32'd1);
    check("flush_data", 32'(data_o), 32'h00);

    // Random mix against a queue model
    m_dout = 8'h00;
    m_ovf  = 1'b0;
    for (int i = 0; i < 48; i++) begin
      logic       we, re, rok, wok;
      logic [7:0] d;
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 3) == 0);
      d  = 8'($urandom_range(0, 255));
      rok = re && (q.size() > 0);
      wok = we && ((q.size() < 16) || rok);
      if (rok) m_dout = q.pop_front();
      if (wok) q.push_back(d);
      if (we && !wok) m_ovf = 1'b1;
      cycle(we, d, re, 1'b0, 1'b0);
      check("rand_count", 32'(count_o), 32'(q.size()));
      check("rand_data", 32'(data_o), 32'(m_dout));
      check("rand_ovf", 32'(ovf_o), 32'(m_ovf));
    end

    // Asynchronous reset between clock edges
    wr(8'h5A);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count_o), 32'd0);
    check("arst_empty", 32'(empty_o), 32'd1);
    check("arst_data", 32'(data_o), 32'h00);
    check("arst_ovf", 32'(ovf_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd();
    check("post_arst_data", 32'(data_o), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
